fft_run_sequencer: RTL and testbench

FFT_RUN_SEQUENCER -- requirements
Module: fft_run_sequencer

---
 rtl/fft_run_sequencer_pkg.sv | 23 ++
 rtl/fft_run_sequencer_watchdog.sv | 30 +++
 rtl/fft_run_sequencer.sv | 133 +++++++++++++
 tb/tb_fft_run_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_run_sequencer_pkg.sv
// Shared types and defaults for the FFT run sequencer.
// The optional watchdog is enabled by defining FFT_SEQ_WATCHDOG_EN.
package pe_pkg;

  localparam int SINK_WIDTH = 14;
  localparam int FFT_DEPTH  = 11;
  localparam int RUNS       = 3;

  typedef logic [SINK_WIDTH-1:0] sample_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILL     = 3'd1,
    KICK     = 3'd2,
    WAIT_FFT = 3'd3,
    FINISH   = 3'd4
  } seq_state_t;

  function automatic int run_bits(input int runs);
    return (runs > 1) ? $clog2(runs) : 1;
  endfunction

endpackage

// File: rtl/fft_run_sequencer_watchdog.sv
// Cycle counter that flags when a wait has lasted LIMIT cycles.
// Only instantiated when FFT_SEQ_WATCHDOG_EN is defined.
module fft_seq_watchdog #(
  parameter int LIMIT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt;

  assign expire = enable && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expire) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fft_run_sequencer.sv
// Fills the sample buffer and kicks the FFT core RUNS times per start.
// Define FFT_SEQ_WATCHDOG_EN to add the WAIT_FFT timeout and error flag.
module fft_run_sequencer
  import pe_pkg::*;
#(
  parameter int SINK_WIDTH     = pe_pkg::SINK_WIDTH,
  parameter int FFT_DEPTH      = pe_pkg::FFT_DEPTH,
  parameter int RUNS           = pe_pkg::RUNS,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         sample_stb,
  input  logic                         fft_busy,
  input  logic                         fft_done,
  output logic                         buf_we,
  output logic [FFT_DEPTH-1:0]         buf_addr,
  output logic                         fft_start,
  output logic [run_bits(RUNS)-1:0]    run_idx,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);

  localparam int RW = run_bits(RUNS);
  localparam logic [FFT_DEPTH-1:0] ADDR_LAST = '1;
  localparam logic [RW-1:0] RUN_LAST = RW'(RUNS - 1);

  if (SINK_WIDTH < 1 || RUNS < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("fft_run_sequencer: invalid parameters");
  end

  seq_state_t           state;
  logic [FFT_DEPTH-1:0] cnt;
  logic                 take_stb;
  logic                 wd_hit;

  assign take_stb = sample_stb && (state == FILL);
  assign busy     = (state != IDLE);
  assign done     = (state == FINISH);

`ifdef FFT_SEQ_WATCHDOG_EN
  logic wd_clear;
  logic wd_enable;
  logic wd_expire;

  assign wd_enable = (state == WAIT_FFT);
  assign wd_clear  = !wd_enable;
  assign wd_hit    = wd_expire && !fft_done;

  fft_seq_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wd (
    .clk   (clk),
    .rst   (rst),
    .clear (wd_clear),
    .enable(wd_enable),
    .expire(wd_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error <= 1'b0;
    end else if (start && state == IDLE) begin
      error <= 1'b0;
    end else if (wd_hit) begin
      error <= 1'b1;
    end
  end
`else
  assign wd_hit = 1'b0;
  assign error  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      run_idx   <= '0;
      buf_we    <= 1'b0;
      buf_addr  <= '0;
      fft_start <= 1'b0;
    end else begin
      buf_we    <= take_stb;
      fft_start <= 1'b0;
      // counter wraps to 0 on the strobe that writes the last address
      if (take_stb) begin
        buf_addr <= cnt;
        cnt      <= cnt + FFT_DEPTH'(1);
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= FILL;
            cnt     <= '0;
            run_idx <= '0;
          end
        end
        FILL: begin
          if (take_stb && cnt == ADDR_LAST) begin
            state <= KICK;
          end
        end
        KICK: begin
          if (!fft_busy) begin
            fft_start <= 1'b1;
            state     <= WAIT_FFT;
          end
        end
        WAIT_FFT: begin
          if (fft_done) begin
            if (run_idx == RUN_LAST) begin
              state <= FINISH;
            end else begin
              run_idx <= run_idx + RW'(1);
              state   <= FILL;
            end
          end else if (wd_hit) begin
            state <= IDLE;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_run_sequencer.sv
// Testbench for fft_run_sequencer (FFT_DEPTH=3, RUNS=3, TIMEOUT_CYCLES=20).
// Watchdog checks follow FFT_SEQ_WATCHDOG_EN.
module tb_fft_run_sequencer;

  localparam int DEPTH = 3;
  localparam int NS    = 8;
  localparam int NRUN  = 3;
  localparam int TMO   = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             sample_stb = 1'b0;
  logic             fft_busy = 1'b0;
  logic             fft_done = 1'b0;
  logic             buf_we;
  logic [DEPTH-1:0] buf_addr;
  logic             fft_start;
  logic [1:0]       run_idx;
  logic             busy;
  logic             done;
  logic             error;

  int tests = 0;
  int fails = 0;

  int wr_run[$];
  int wr_addr[$];
  int st_run[$];
  int done_cnt = 0;

  typedef struct {
    int busy_cyc;
    int done_lat;
    bit noise_fill;
    bit noise_kick;
    bit coincide;
    int exp_writes;
    int exp_starts;
    int exp_dones;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  fft_run_sequencer #(
    .SINK_WIDTH    (14),
    .FFT_DEPTH     (DEPTH),
    .RUNS          (NRUN),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sample_stb(sample_stb),
    .fft_busy  (fft_busy),
    .fft_done  (fft_done),
    .buf_we    (buf_we),
    .buf_addr  (buf_addr),
    .fft_start (fft_start),
    .run_idx   (run_idx),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (buf_we) begin
        wr_run.push_back(int'(run_idx));
        wr_addr.push_back(int'(buf_addr));
      end
      if (fft_start) st_run.push_back(int'(run_idx));
      if (done) done_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    wr_run.delete();
    wr_addr.delete();
    st_run.delete();
    done_cnt = 0;
  endtask

  // acquisition expectation: N writes per run, addr i%N, run i/N
  task automatic check_sb(input vec_t v, input string tag);
    int bad;
    bad = 0;
    chk({tag, " write count"}, wr_run.size(), v.exp_writes);
    for (int i = 0; i < wr_run.size(); i++) begin
      if (wr_run[i] != i / NS || wr_addr[i] != i % NS) bad++;
    end
    chk({tag, " write order errors"}, bad, 0);
    chk({tag, " fft_start count"}, st_run.size(), v.exp_starts);
    bad = 0;
    for (int i = 0; i < st_run.size(); i++) begin
      if (st_run[i] != i) bad++;
    end
    chk({tag, " fft_start run order"}, bad, 0);
    chk({tag, " done count"}, done_cnt, v.exp_dones);
  endtask

  task automatic do_start(input bit coincide);
    start = 1'b1;
    sample_stb = coincide;
    tick();
    start = 1'b0;
    sample_stb = 1'b0;
  endtask

  task automatic do_strobes(input int n, input bit noise, input bit last_busy);
    for (int s = 0; s < n; s++) begin
      int gap;
      gap = $urandom_range(1, 2);
      for (int g = 0; g < gap; g++) begin
        if (noise && s == 3 && g == 0) begin
          start = 1'b1;
          fft_done = 1'b1;
        end
        tick();
        start = 1'b0;
        fft_done = 1'b0;
      end
      sample_stb = 1'b1;
      fft_busy = last_busy && (s == n - 1);
      tick();
      sample_stb = 1'b0;
    end
  endtask

  task automatic run_acq(input vec_t v, input string tag);
    clear_sb();
    tick();
    do_start(v.coincide);
    for (int r = 0; r < NRUN; r++) begin
      do_strobes(NS, v.noise_fill, v.busy_cyc > 0);
      for (int k = 0; k < v.busy_cyc; k++) begin
        sample_stb = v.noise_kick ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
      end
      sample_stb = 1'b0;
      fft_busy = 1'b0;
      chk({tag, " fft_start held in KICK"}, fft_start, 0);
      tick();
      chk({tag, " fft_start after busy"}, fft_start, 1);
      for (int k = 0; k < v.done_lat - 1; k++) begin
        sample_stb = v.noise_kick ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
      end
      sample_stb = 1'b0;
      fft_done = 1'b1;
      tick();
      fft_done = 1'b0;
    end
    chk({tag, " done pulse"}, {30'd0, done, busy}, 3);
    tick();
    chk({tag, " idle after done"}, {30'd0, done, busy}, 0);
    repeat (3) tick();
    check_sb(v, tag);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    fft_busy = 1'b0;
    start = 1'b0;
    sample_stb = 1'b0;
    fft_done = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    vecs[0] = '{0, 5, 0, 0, 0, NS * NRUN, NRUN, 1};
    vecs[1] = '{10, 5, 0, 1, 0, NS * NRUN, NRUN, 1};
    vecs[2] = '{3, 1, 1, 1, 1, NS * NRUN, NRUN, 1};
    vecs[3] = '{1, 7, 1, 0, 1, NS * NRUN, NRUN, 1};
    for (int i = 4; i < 7; i++) begin
      vecs[i] = '{int'($urandom_range(0, 6)), int'($urandom_range(1, 8)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), NS * NRUN, NRUN, 1};
    end

    repeat (2) tick();
    chk("reset outputs",
        {22'd0, buf_we, buf_addr, fft_start, run_idx, busy, done, error}, 0);
    rst = 1'b0;
    tick();
    chk("idle not busy", busy, 0);

    for (int i = 0; i < 7; i++) begin
      run_acq(vecs[i], $sformatf("vec%0d", i));
    end

    // abort in run 1 right after address 4 is written
    clear_sb();
    do_start(1'b0);
    do_strobes(NS, 1'b0, 1'b0);
    tick();
    chk("rst seq fft_start", fft_start, 1);
    repeat (4) tick();
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    do_strobes(5, 1'b0, 1'b0);
    chk("rst seq pre-abort write",
        {27'd0, buf_we, buf_addr, run_idx}, {27'd0, 1'b1, 3'd4, 2'd1});
    #2;
    rst = 1'b1;
    #1;
    chk("async reset outputs",
        {22'd0, buf_we, buf_addr, fft_start, run_idx, busy, done, error}, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("no done after abort", done_cnt, 0);
    do_start(1'b0);
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
    chk("fresh run first write",
        {27'd0, buf_we, buf_addr, run_idx}, {27'd0, 1'b1, 3'd0, 2'd0});
    apply_reset();

`ifdef FFT_SEQ_WATCHDOG_EN
    clear_sb();
    do_start(1'b0);
    do_strobes(NS, 1'b0, 1'b0);
    tick();
    chk("wd fft_start", fft_start, 1);
    repeat (TMO - 1) tick();
    chk("wd before expiry", {30'd0, error, busy}, 1);
    tick();
    chk("wd expired", {30'd0, error, busy}, 2);
    chk("wd no done", done_cnt, 0);
    do_start(1'b0);
    chk("wd error cleared", {30'd0, error, busy}, 1);
    apply_reset();
`else
    do_start(1'b0);
    do_strobes(NS, 1'b0, 1'b0);
    tick();
    chk("no-wd fft_start", fft_start, 1);
    repeat (200) tick();
    chk("no-wd still waiting", {30'd0, error, busy}, 1);
    apply_reset();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
